// File: rtl/bcd_serial_adder_ctrl_if.sv
// Requester-side handshake bundle for the serial BCD adder controller.
// The requester drives start/operands; the controller returns status and result.
interface bcd_serial_adder_ctrl_if #(
   parameter int DIGITS = 4
);
   logic                  start;
   logic [4*DIGITS-1:0]   a;
   logic [4*DIGITS-1:0]   b;
   logic                  cin;
   logic                  busy;
   logic                  done;
   logic [4*DIGITS-1:0]   sum;
   logic                  cout;
   logic                  err;

   modport master (
      output start, a, b, cin,
      input  busy, done, sum, cout, err
   );

   modport slave (
      input  start, a, b, cin,
      output busy, done, sum, cout, err
   );
endinterface

// File: rtl/bcd_serial_adder_ctrl.sv
// Multi-digit BCD adder controller sharing one external one-digit adder.
// Optional operand digit check enabled by defining BCD_INVALID_CHECK_EN.
module bcd_serial_adder_ctrl #(
   parameter int DIGITS = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   bcd_serial_adder_ctrl_if.slave bus,
   output logic [3:0]             add_a,
   output logic [3:0]             add_b,
   output logic                   add_cin,
   input  logic [3:0]             add_s,
   input  logic                   add_cout
);
   localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   typedef enum logic [1:0] {
      IDLE,
      ADD,
      DONE
   } state_t;

   state_t                 state;
   state_t                 state_d;
   logic [IW-1:0]          idx;
   logic                   carry;
   logic [DIGITS-1:0][3:0] a_r;
   logic [DIGITS-1:0][3:0] b_r;
   logic [DIGITS-1:0][3:0] sum_r;
   logic                   cout_r;
   logic                   accept;
   logic                   last;
   logic                   bad_ops;

   assign accept = bus.start && (state != ADD);
   assign last   = (idx == IW'(DIGITS - 1));

`ifdef BCD_INVALID_CHECK_EN
   logic err_r;

   function automatic logic any_bad(input logic [4*DIGITS-1:0] v);
      logic r;
      r = 1'b0;
      for (int i = 0; i < DIGITS; i++) begin
         if (v[4*i +: 4] > 4'd9) r = 1'b1;
      end
      return r;
   endfunction

   assign bad_ops = any_bad(bus.a) || any_bad(bus.b);
   assign bus.err = err_r;
`else
   assign bad_ops = 1'b0;
   assign bus.err = 1'b0;
`endif

   always_comb begin
      state_d = state;
      unique case (state)
         IDLE: if (accept) state_d = bad_ops ? DONE : ADD;
         ADD:  if (last) state_d = DONE;
         DONE: begin
            if (accept) state_d = bad_ops ? DONE : ADD;
            else        state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      add_a   = 4'd0;
      add_b   = 4'd0;
      add_cin = 1'b0;
      if (state == ADD) begin
         add_a   = a_r[idx];
         add_b   = b_r[idx];
         add_cin = carry;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         idx    <= '0;
         carry  <= 1'b0;
         a_r    <= '0;
         b_r    <= '0;
         sum_r  <= '0;
         cout_r <= 1'b0;
`ifdef BCD_INVALID_CHECK_EN
         err_r  <= 1'b0;
`endif
      end else begin
         state <= state_d;
         if (accept) begin
            a_r   <= bus.a;
            b_r   <= bus.b;
            carry <= bus.cin;
            idx   <= '0;
`ifdef BCD_INVALID_CHECK_EN
            err_r <= bad_ops;
`endif
            // Rejected operands publish a cleared result alongside err.
            if (bad_ops) begin
               sum_r  <= '0;
               cout_r <= 1'b0;
            end
         end else if (state == ADD) begin
            sum_r[idx] <= add_s;
            carry      <= add_cout;
            if (last) cout_r <= add_cout;
            else      idx    <= idx + 1'b1;
         end
      end
   end

   assign bus.busy = (state == ADD);
   assign bus.done = (state == DONE);
   assign bus.sum  = sum_r;
   assign bus.cout = cout_r;
endmodule

// File: tb/tb_bcd_serial_adder_ctrl.sv
// Self-checking bench for bcd_serial_adder_ctrl with a behavioural one-digit adder.
// Table vectors, hand sequences for corner cases and a done-driven scoreboard.
module tb_bcd_serial_adder_ctrl;
   localparam int DIGITS = 4;

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic        cin;
      logic [15:0] s;
      logic        co;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [3:0]  add_a, add_b, add_s;
   logic        add_cin, add_cout;
   logic [4:0]  dsum;
   int          n_checks = 0;
   int          n_fail = 0;
   int          cyc = 0;
   logic [17:0] exp_q[$];

   bcd_serial_adder_ctrl_if #(.DIGITS(DIGITS)) bus ();

   bcd_serial_adder_ctrl #(.DIGITS(DIGITS)) u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .bus      (bus),
      .add_a    (add_a),
      .add_b    (add_b),
      .add_cin  (add_cin),
      .add_s    (add_s),
      .add_cout (add_cout)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   // Behavioural one-digit BCD adder with decimal correction.
   always_comb begin
      dsum = {1'b0, add_a} + {1'b0, add_b} + {4'b0, add_cin};
      if (dsum > 5'd9) begin
         add_s    = dsum[3:0] + 4'd6;
         add_cout = 1'b1;
      end else begin
         add_s    = dsum[3:0];
         add_cout = 1'b0;
      end
   end

   function automatic logic [16:0] ref_add(input logic [15:0] x, input logic [15:0] y,
                                           input logic c);
      int xv, yv, t;
      logic [15:0] s;
      xv = 0;
      yv = 0;
      for (int i = 3; i >= 0; i--) begin
         xv = xv * 10 + int'(x[4*i +: 4]);
         yv = yv * 10 + int'(y[4*i +: 4]);
      end
      t = xv + yv + int'(c);
      ref_add[16] = (t >= 10000);
      t = t % 10000;
      for (int i = 0; i < 4; i++) begin
         s[4*i +: 4] = 4'(t % 10);
         t = t / 10;
      end
      ref_add[15:0] = s;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, req);
      end
   endtask

   // Scoreboard: each done pulse pops one expected {err,cout,sum}.
   always @(negedge clk) begin
      if (rst_n && bus.done) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_done: got done=1 expected no pending op");
         end else begin
            check("result", {14'd0, bus.err, bus.cout, bus.sum}, {14'd0, exp_q.pop_front()});
         end
      end
   end

   task automatic wait_done(input int max, output int lat, output int busy_n);
      lat = 0;
      busy_n = 0;
      while (!bus.done && lat < max) begin
         if (bus.busy) busy_n++;
         @(posedge clk);
         #1;
         lat++;
      end
      if (!bus.done) begin
         n_checks++;
         n_fail++;
         $display("FAIL timeout: got no done after %0d cycles expected done", lat);
      end
   endtask

   task automatic run_op(input logic [15:0] av, input logic [15:0] bv, input logic ci,
                         input logic [17:0] e);
      int lat, bn;
      @(negedge clk);
      bus.a = av;
      bus.b = bv;
      bus.cin = ci;
      bus.start = 1'b1;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      wait_done(20, lat, bn);
      check("latency", lat, DIGITS);
      check("busy_cycles", bn, DIGITS);
      @(posedge clk);
      #1;
      check("hold", {13'd0, bus.done, bus.err, bus.cout, bus.sum}, {13'd0, 1'b0, e});
   endtask

   initial begin
      vec_t        tbl[8];
      int          lat, bn, t1, t2;
      logic [15:0] ra, rb;
      logic        rc;
      logic [16:0] r;

      tbl[0] = '{16'h1234, 16'h8766, 1'b0, 16'h0000, 1'b1};
      tbl[1] = '{16'h9999, 16'h0000, 1'b1, 16'h0000, 1'b1};
      tbl[2] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0};
      tbl[3] = '{16'h5000, 16'h5000, 1'b0, 16'h0000, 1'b1};
      tbl[4] = '{16'h0999, 16'h0001, 1'b0, 16'h1000, 1'b0};
      tbl[5] = '{16'h4321, 16'h1234, 1'b1, 16'h5556, 1'b0};
      tbl[6] = '{16'h9999, 16'h9999, 1'b1, 16'h9999, 1'b1};
      tbl[7] = '{16'h0005, 16'h0005, 1'b0, 16'h0010, 1'b0};

      rst_n = 1'b0;
      bus.start = 1'b0;
      bus.a = '0;
      bus.b = '0;
      bus.cin = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("reset_state",
            {7'd0, bus.busy, bus.done, bus.err, bus.cout, add_a, add_b, add_cin, bus.sum},
            32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 8; i++)
         run_op(tbl[i].a, tbl[i].b, tbl[i].cin, {1'b0, tbl[i].co, tbl[i].s});

      // start during busy must be ignored
      @(negedge clk);
      bus.a = 16'h0456;
      bus.b = 16'h0123;
      bus.cin = 1'b1;
      bus.start = 1'b1;
      exp_q.push_back({2'b00, 16'h0580});
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      @(posedge clk);
      #1;
      bus.start = 1'b1;
      bus.a = 16'h9999;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      bus.a = 16'h0000;
      wait_done(20, lat, bn);
      check("ignored_start_lat", lat, 2);

      // back-to-back with start held across done
      @(negedge clk);
      bus.a = 16'h0005;
      bus.b = 16'h0005;
      bus.cin = 1'b0;
      bus.start = 1'b1;
      exp_q.push_back({2'b00, 16'h0010});
      @(posedge clk);
      #1;
      bus.a = 16'h0010;
      bus.b = 16'h0020;
      exp_q.push_back({2'b00, 16'h0030});
      wait_done(20, lat, bn);
      t1 = cyc;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      check("b2b_busy_after_done", {31'd0, bus.busy}, 32'd1);
      wait_done(20, lat, bn);
      t2 = cyc;
      check("b2b_spacing", t2 - t1, DIGITS + 1);
      @(posedge clk);
      #1;

      // asynchronous reset in the middle of an addition
      @(negedge clk);
      bus.a = 16'h5555;
      bus.b = 16'h5555;
      bus.start = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check("mid_reset",
            {7'd0, bus.busy, bus.done, bus.err, bus.cout, add_a, add_b, add_cin, bus.sum},
            32'd0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("post_reset_idle", {30'd0, bus.busy, bus.done}, 32'd0);
      run_op(16'h0001, 16'h0001, 1'b0, {2'b00, 16'h0002});

      for (int k = 0; k < 6; k++) begin
         for (int d = 0; d < 4; d++) begin
            ra[4*d +: 4] = 4'($urandom_range(0, 9));
            rb[4*d +: 4] = 4'($urandom_range(0, 9));
         end
         rc = 1'($urandom_range(0, 1));
         r = ref_add(ra, rb, rc);
         run_op(ra, rb, rc, {1'b0, r});
      end

`ifdef BCD_INVALID_CHECK_EN
      @(negedge clk);
      bus.a = 16'h00A1;
      bus.b = 16'h0001;
      bus.cin = 1'b0;
      bus.start = 1'b1;
      exp_q.push_back({2'b10, 16'h0000});
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      check("invalid_done_next", {31'd0, bus.done}, 32'd1);
      repeat (2) @(posedge clk);
      #1;
      check("invalid_err_held", {31'd0, bus.err}, 32'd1);
      run_op(16'h0011, 16'h0022, 1'b0, {2'b00, 16'h0033});
`endif

      repeat (3) @(posedge clk);
      #1;
      check("queue_empty", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/bcd_serial_adder_ctrl.md
Name: bcd_serial_adder_ctrl

Overview:
Multi-digit BCD adder controller. It adds two DIGITS-wide packed BCD operands one digit per clock, time-sharing a single external combinational one-digit bcd_adder. It owns the digit counter, the inter-digit carry register, operand/result registers and a start/busy/done handshake. It sits between a requester (e.g. a calculator/accumulator FSM) and the one-digit adder instance.

Parameters:
DIGITS, 4, number of BCD digits per operand; legal range 1..16.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
start  input  1  request; sampled on rising clk edge.
a  input  4*DIGITS  operand A, packed BCD; digit 0 in bits [3:0].
b  input  4*DIGITS  operand B, packed BCD.
cin  input  1  carry into digit 0.
busy  output  1  high while the controller is in ADD.
done  output  1  one-cycle pulse; sum/cout are valid.
sum  output  4*DIGITS  registered packed BCD result.
cout  output  1  registered carry out of the top digit.
err  output  1  invalid-digit flag; see Optional Feature.
add_a  output  4  digit A driven to the one-digit adder.
add_b  output  4  digit B driven to the one-digit adder.
add_cin  output  1  carry driven to the one-digit adder.
add_s  input  4  digit sum returned by the one-digit adder.
add_cout  input  1  digit carry returned by the one-digit adder.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, idx=0, carry=0, operand registers=0, sum=0, cout=0, done=0, busy=0, err=0. Reset mid-ADD aborts the addition; no done pulse is produced.
- States: IDLE, ADD, DONE. done is high exactly when state=DONE. busy is high exactly when state=ADD.
- IDLE or DONE with start=1 at an edge:
  - latch a and b into a_r and b_r.
  - carry<=cin, idx<=0, go to ADD.
  - sum and cout keep their previous values until overwritten.
- IDLE with start=0: stay in IDLE.
- DONE with start=0: go to IDLE.
- ADD, combinational outputs:
  - add_a=a_r digit idx.
  - add_b=b_r digit idx.
  - add_cin=carry.
- ADD, at each edge:
  - sum digit idx <= add_s.
  - carry <= add_cout.
  - if idx=DIGITS-1: cout<=add_cout, go to DONE.
  - otherwise idx<=idx+1.
- Outside ADD: add_a=0, add_b=0, add_cin=0.
- Latency: start is sampled at edge 0. Digits are captured at edges 1..DIGITS. done is high in the cycle after edge DIGITS (DIGITS+1 cycles after start). Throughput with back-to-back starts is one result per DIGITS+1 cycles.
- start while busy=1 is ignored. No queuing, and operands are not re-latched.
- Changes on a or b after the start edge do not affect the result.
- sum and cout hold their value after done until the next accepted operation writes them digit by digit.
- The controller never corrects digits itself; BCD correction is done by the one-digit adder.
- idx width is clog2(DIGITS), minimum 1 bit. idx never exceeds DIGITS-1.

Optional Feature:
Macro name: BCD_INVALID_CHECK_EN.
- Defined:
  - On an accepted start, if any digit of a or b is >9, go directly to DONE.
  - In that cycle set sum=0, cout=0, err=1.
  - err stays high until the next accepted start; a valid start clears err to 0.
- Not defined: no operand check; err is tied to 0; invalid digits are passed to the adder unchanged.

Test Plan:
Scenarios use DIGITS=4, with the real bcd_adder connected.
- a=0x1234, b=0x8766, cin=0, single start pulse -> busy for 4 cycles; done 5 cycles after start; sum=0x0000, cout=1.
- a=0x9999, b=0x0000, cin=1 -> sum=0x0000, cout=1. a=0x0000, b=0x0000, cin=0 -> sum=0x0000, cout=0. Each done is a single-cycle pulse.
- a=0x0456, b=0x0123, cin=1, then start=1 again with a=0x9999 during busy -> second start ignored; sum=0x0580, cout=0.
- Back-to-back: start held high across done, with a=0x0005, b=0x0005 then a=0x0010, b=0x0020 -> results 0x0010 and 0x0030; successive done pulses are exactly 5 cycles apart.
- rst_n driven low during ADD of a=0x5555, b=0x5555 -> all outputs 0 immediately; no done; the next start (0x0001+0x0001) yields 0x0002.
- With BCD_INVALID_CHECK_EN: a=0x00A1, b=0x0001 -> done on the cycle after start; err=1, sum=0. Next valid start clears err.
